dsm_dac_hd: RTL

Parametrised delta-sigma DAC modulator with selectable order (1 or 2), built-in oversampling-ratio sample pacing and a one-entry valid/ready input buffer. It sits between a sample source at the base rate and a single-bit output pin, and replaces the fixed first-order modulator path. Integrators saturate instead of wrapping, and a sticky flag reports the event. Starved sample slots raise an underrun pulse.

---
 rtl/dsm_pkg.sv | 34 +++
 rtl/dsm_sat_integrator.sv | 39 +++
 rtl/dsm_dac_hd.sv | 142 ++++++++++++++
 3 files changed

// File: rtl/dsm_pkg.sv
// Shared definitions for the delta-sigma DAC modulator: legal order values,
// feedback magnitude and the saturating adder used by every integrator.
package dsm_pkg;

  localparam int ORDER_FIRST  = 1;
  localparam int ORDER_SECOND = 2;

  // Feedback magnitude: one full-scale step of a DATA_WIDTH-bit signed sample.
  function automatic longint fb_mag(input int data_width);
    return longint'(1) <<< (data_width - 1);
  endfunction

  // Adds two values and clamps the result into an acc_width-bit signed range.
  function automatic longint sat_add(input longint a, input longint b, input int acc_width);
    longint s;
    longint hi;
    longint lo;
    s  = a + b;
    hi = (longint'(1) <<< (acc_width - 1)) - longint'(1);
    lo = -(longint'(1) <<< (acc_width - 1));
    if (s > hi) begin
      s = hi;
    end else if (s < lo) begin
      s = lo;
    end
    return s;
  endfunction

  // True when sat_add would have had to clamp the same operands.
  function automatic logic sat_clamped(input longint a, input longint b, input int acc_width);
    return sat_add(a, b, acc_width) != (a + b);
  endfunction

endpackage

// File: rtl/dsm_sat_integrator.sv
// One enable-gated saturating accumulator: acc <= sat(acc + in - fb).
// The clamp flag is only raised in cycles where the accumulator advances.
module dsm_sat_integrator
  import dsm_pkg::*;
#(
  parameter int ACC_WIDTH = 20
) (
  input  logic                        i_clk,
  input  logic                        i_rst,
  input  logic                        i_en,
  input  logic signed [ACC_WIDTH-1:0] i_in,
  input  logic signed [ACC_WIDTH-1:0] i_fb,
  output logic signed [ACC_WIDTH-1:0] o_acc,
  output logic                        o_clamp
);

  logic signed [ACC_WIDTH-1:0] r_acc;
  logic signed [ACC_WIDTH+1:0] w_part;
  logic signed [ACC_WIDTH-1:0] w_next;
  logic                        w_hit;

  // Two guard bits keep acc + in - fb exact before the clamp.
  assign w_part = {{2{r_acc[ACC_WIDTH-1]}}, r_acc} + {{2{i_in[ACC_WIDTH-1]}}, i_in};
  assign w_next = ACC_WIDTH'(sat_add(longint'(w_part), -longint'(i_fb), ACC_WIDTH));
  assign w_hit  = sat_clamped(longint'(w_part), -longint'(i_fb), ACC_WIDTH);

  // Accumulator register: frozen while disabled, cleared by reset.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_acc <= '0;
    end else if (i_en) begin
      r_acc <= w_next;
    end
  end

  assign o_acc   = r_acc;
  assign o_clamp = i_en & w_hit;

endmodule

// File: rtl/dsm_dac_hd.sv
// Delta-sigma DAC modulator (order 1 or 2) with OSR sample pacing, a one-entry
// valid/ready input buffer, saturating integrators, a sticky overflow flag and
// an underrun pulse for starved sample slots.
module dsm_dac_hd
  import dsm_pkg::*;
#(
  parameter int DATA_WIDTH = 16,
  parameter int ACC_WIDTH  = DATA_WIDTH + 4,
  parameter int ORDER      = 2,
  parameter int OSR        = 64
) (
  input  logic                         i_clk,
  input  logic                         i_rst,
  input  logic                         i_en,
  input  logic signed [DATA_WIDTH-1:0] i_data,
  input  logic                         i_valid,
  output logic                         o_ready,
  input  logic                         i_clr_overflow,
  output logic                         o_dac_bitstream,
  output logic                         o_underrun,
  output logic                         o_overflow
);

  localparam int CNT_W = $clog2(OSR);
  localparam logic signed [ACC_WIDTH-1:0] FB_POS   = ACC_WIDTH'(fb_mag(DATA_WIDTH));
  localparam logic signed [ACC_WIDTH-1:0] FB_NEG   = -FB_POS;
  localparam logic signed [ACC_WIDTH-1:0] ACC_ZERO = '0;

  if (ORDER != ORDER_FIRST && ORDER != ORDER_SECOND) begin : g_bad_order
    $error("dsm_dac_hd: ORDER must be 1 or 2");
  end
  if (ACC_WIDTH < DATA_WIDTH + 2 || ACC_WIDTH + 2 > 64) begin : g_bad_acc
    $error("dsm_dac_hd: ACC_WIDTH must be in DATA_WIDTH+2 .. 62");
  end
  if (OSR < 2) begin : g_bad_osr
    $error("dsm_dac_hd: OSR must be at least 2");
  end

  logic [CNT_W-1:0]             r_cnt;
  logic                         w_strobe;
  logic                         w_accept;
  logic signed [DATA_WIDTH-1:0] r_pend;
  logic                         r_pend_vld;
  logic signed [DATA_WIDTH-1:0] r_sample;
  logic                         r_underrun;
  logic                         r_overflow;
  logic signed [ACC_WIDTH-1:0]  w_sample_ext;
  logic signed [ACC_WIDTH-1:0]  w_fb;
  logic                         w_bit;
  logic signed [ACC_WIDTH-1:0]  w_in  [ORDER];
  logic signed [ACC_WIDTH-1:0]  w_acc [ORDER];
  logic [ORDER-1:0]             w_clamp;

  assign w_strobe = i_en && (r_cnt == CNT_W'(OSR - 1));
  assign w_accept = i_valid && !r_pend_vld;
  assign o_ready  = !r_pend_vld;

  // OSR pacing counter: advances only when enabled, wraps after OSR-1.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_cnt <= '0;
    end else if (i_en) begin
      r_cnt <= w_strobe ? '0 : r_cnt + CNT_W'(1);
    end
  end

  // One-entry input buffer; accept and drain are mutually exclusive because
  // accept needs the buffer empty and drain needs it full.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_pend     <= '0;
      r_pend_vld <= 1'b0;
    end else if (w_accept) begin
      r_pend     <= i_data;
      r_pend_vld <= 1'b1;
    end else if (w_strobe && r_pend_vld) begin
      r_pend_vld <= 1'b0;
    end
  end

  // Modulator input sample: reloaded on a strobe, held when starved.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_sample <= '0;
    end else if (w_strobe && r_pend_vld) begin
      r_sample <= r_pend;
    end
  end

  // Underrun pulse, one cycle after a strobe that found no pending sample.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_underrun <= 1'b0;
    end else begin
      r_underrun <= w_strobe && !r_pend_vld;
    end
  end

  // Sticky overflow: a clamp in the same cycle beats a clear request.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_overflow <= 1'b0;
    end else if (|w_clamp) begin
      r_overflow <= 1'b1;
    end else if (i_clr_overflow) begin
      r_overflow <= 1'b0;
    end
  end

  assign w_sample_ext = {{(ACC_WIDTH - DATA_WIDTH){r_sample[DATA_WIDTH-1]}}, r_sample};

  // Quantizer reads the registered last integrator directly (sign test), so
  // the bitstream carries no extra register stage.
  assign w_bit = (w_acc[ORDER-1] >= ACC_ZERO);
  assign w_fb  = w_bit ? FB_POS : FB_NEG;

  // Integrator chain; stage k>0 consumes the pre-update value of stage k-1.
  for (genvar k = 0; k < ORDER; k++) begin : g_int
    if (k == 0) begin : g_first
      assign w_in[k] = w_sample_ext;
    end else begin : g_next
      assign w_in[k] = w_acc[k-1];
    end

    dsm_sat_integrator #(
      .ACC_WIDTH(ACC_WIDTH)
    ) u_int (
      .i_clk  (i_clk),
      .i_rst  (i_rst),
      .i_en   (i_en),
      .i_in   (w_in[k]),
      .i_fb   (w_fb),
      .o_acc  (w_acc[k]),
      .o_clamp(w_clamp[k])
    );
  end

  assign o_dac_bitstream = w_bit;
  assign o_underrun      = r_underrun;
  assign o_overflow      = r_overflow;

endmodule
